gesture_sequencer: RTL
======================

Name: gesture_sequencer

Overview:
- Sequences the five finger servos through a stored hand gesture on a button press.
- Sits between the switch/button inputs and the five PWM generators, and drives a per-servo angle command (0..180 degrees) to each generator.
- Motion is slew-limited. Positions update only on the PWM frame tick (one per 20 ms frame at 50 MHz), so each generator sees at most one new angle per frame.
- A gesture is two keyframes: move to the pose, hold it, then return to neutral.

Parameters:
- STEP_DEG, 6, maximum angle change per servo per frame_tick (1..90).
- HOLD_FRAMES, 25, frame_ticks spent holding keyframe 0 (>=1; 25 = 0.5 s).
- NEUTRAL_DEG, 90, reset/idle angle and target of keyframe 1.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- gesture_sel  in  8  one-hot gesture select (switch bank).
- start  in  1  single-cycle request pulse (debounced button).
- frame_tick  in  1  single-cycle pulse at the start of each PWM frame.
- pos1..pos5  out  8 each  angle command in degrees to PWM channels 1..5.
- busy  out  1  a gesture is in progress.
- done  out  1  single-cycle pulse when the gesture completes.
- err  out  1  single-cycle pulse when a start request is rejected.
- active_gesture  out  2  index of the latched gesture.

Behaviour:
- Reset (asynchronous, immediate): pos1..pos5 = NEUTRAL_DEG; busy, done, err = 0; active_gesture = 0; state = IDLE; keyframe index = 0; hold counter = 0.
- Gesture ROM, keyframe 0 angles for pos1..pos5:
  - G0 (bit0), fist: 180,180,180,180,180
  - G1 (bit1), point: 0,180,180,180,180
  - G2 (bit2), peace: 180,0,0,180,180
  - G3 (bit3), open: 0,0,0,0,0
  - Keyframe 1 for every gesture: all NEUTRAL_DEG.
- Valid select: exactly one of gesture_sel[3:0] set and gesture_sel[7:4] = 0. Anything else is invalid.
- States:
  - IDLE: on start with a valid select, latch active_gesture, load keyframe-0 targets, go to MOVE; busy = 1 from the next cycle. On start with an invalid select, err = 1 for one cycle; stay in IDLE; positions unchanged.
  - MOVE: on each frame_tick, each servo updates independently: if |target - pos| <= STEP_DEG, pos = target; otherwise pos moves STEP_DEG toward target. Compute in 9-bit signed so nothing wraps. Arrival (all five pos equal their targets) is evaluated on the updated values in the same cycle:
    - keyframe 0 reached: go to HOLD, counter = HOLD_FRAMES.
    - keyframe 1 reached: go to DONE.
  - HOLD: each frame_tick decrements the counter. The tick that makes it 0 loads keyframe-1 targets and enters MOVE; motion starts on the next tick.
  - DONE: done = 1 and busy = 0 for one cycle, then IDLE. Positions stay at NEUTRAL_DEG.
- Outside MOVE, positions never change.
- start while busy (MOVE, HOLD or DONE) is ignored: no err, select not re-latched.
- gesture_sel changes during a gesture have no effect.
- start and frame_tick in the same IDLE cycle: start is accepted, and that tick does not produce motion.
- A gesture whose pose equals the current positions (STEP_DEG large) still completes: arrival on the first tick in MOVE.
- rst mid-gesture: positions snap to NEUTRAL_DEG immediately and no done pulse is generated.

Test Plan:
1. Assert rst with frame_tick running -> pos1..5 = 90, busy = 0, done = 0, err = 0. Release, no start -> outputs unchanged for 10 ticks.
2. gesture_sel = 8'b00000001, start pulse, defaults:
   - pos1..5 = 96 after tick 1; 180 after tick 15 (busy = 1).
   - Held 180 for 25 ticks, then 174 after tick 41; 90 after tick 55.
   - done pulses once the cycle after tick 55, busy drops; active_gesture = 0.
3. gesture_sel = 8'b00000010, defaults -> pos1 = 84, 78, ... reaching 0 at tick 15 while pos2..5 reach 180. Rerun with STEP_DEG = 7 -> pos2 reads 174 at tick 12 and 180 at tick 13; pos1 reads 6 at tick 12 and 0 at tick 13.
4. gesture_sel = 8'b00000011, then 8'b00010000, start each -> err = 1 for exactly one cycle each; busy stays 0; positions stay 90.
5. During G2 HOLD, set gesture_sel = 8'b00001000 and pulse start -> ignored: no err, active_gesture stays 2, sequence finishes unchanged. Separately, start coincident with frame_tick from IDLE -> first motion on the following tick.
6. Assert rst while G3 is in MOVE at pos = 42 -> all pos = 90 without waiting for a clock edge, busy = 0, no done pulse. After release, a new start runs normally.

Source files
------------

// File: rtl/gesture_sequencer.sv
// gesture_sequencer
// Plays a stored two-keyframe hand gesture on the five finger servos when the
// start button is pressed. The servos move to the gesture pose, hold it for
// HOLD_FRAMES frames, then return to neutral. Each servo moves at most
// STEP_DEG per PWM frame, and positions change only on frame_tick.
//
// Ports:
//   CLOCK_50        in   system clock (50 MHz)
//   rst             in   asynchronous active-high reset
//   gesture_sel     in   one-hot gesture select, bits [3:0] valid, [7:4] must be 0
//   start           in   single-cycle start request
//   frame_tick      in   single-cycle pulse at the start of each PWM frame
//   pos1..pos5      out  angle command in degrees (0..180) per finger servo
//   busy            out  gesture in progress
//   done            out  single-cycle pulse when a gesture completes
//   err             out  single-cycle pulse when a start request is rejected
//   active_gesture  out  index of the latched gesture
module gesture_sequencer #(
  parameter int STEP_DEG    = 6,
  parameter int HOLD_FRAMES = 25,
  parameter int NEUTRAL_DEG = 90
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic [7:0] gesture_sel,
  input  logic       start,
  input  logic       frame_tick,
  output logic [7:0] pos1,
  output logic [7:0] pos2,
  output logic [7:0] pos3,
  output logic [7:0] pos4,
  output logic [7:0] pos5,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] active_gesture
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [7:0]        NEUTRAL8 = 8'(NEUTRAL_DEG);
  localparam logic [7:0]        STEP8    = 8'(STEP_DEG);
  localparam logic signed [8:0] STEP9    = 9'(STEP_DEG);
  localparam logic [HW-1:0]     HOLD_INIT = HW'(HOLD_FRAMES);
  localparam logic [HW-1:0]     HOLD_ONE  = HW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  logic [7:0]    r_pos [5];
  logic [7:0]    r_tgt [5];
  logic          r_kf;        // 0: heading to pose, 1: heading back to neutral
  logic [HW-1:0] r_hold;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic [1:0]    r_gest;

  logic [7:0]    w_next_pos [5];
  logic          w_arrive;
  logic          w_sel_valid;
  logic [1:0]    w_sel_idx;

  // Keyframe-0 angle of one channel for a gesture.
  function automatic logic [7:0] rom_angle(input logic [1:0] g, input logic [2:0] ch);
    logic [7:0] a;
    case (g)
      2'd0:    a = 8'd180;
      2'd1:    a = (ch == 3'd0) ? 8'd0 : 8'd180;
      2'd2:    a = ((ch == 3'd1) || (ch == 3'd2)) ? 8'd0 : 8'd180;
      2'd3:    a = 8'd0;
      default: a = NEUTRAL8;
    endcase
    return a;
  endfunction

  // One slew-limited step toward the target; the 9-bit signed difference
  // keeps the full -180..180 range without wrapping.
  function automatic logic [7:0] slew(input logic [7:0] p, input logic [7:0] t);
    logic signed [8:0] diff;
    logic [7:0]        n;
    diff = $signed({1'b0, t}) - $signed({1'b0, p});
    if (diff > STEP9) begin
      n = p + STEP8;
    end else if (diff < -STEP9) begin
      n = p - STEP8;
    end else begin
      n = t;
    end
    return n;
  endfunction

  // Select decode: exactly one of bits [3:0] set and upper nibble clear.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = 2'd0;
    if (gesture_sel[7:4] == 4'b0000) begin
      case (gesture_sel[3:0])
        4'b0001: begin w_sel_valid = 1'b1; w_sel_idx = 2'd0; end
        4'b0010: begin w_sel_valid = 1'b1; w_sel_idx = 2'd1; end
        4'b0100: begin w_sel_valid = 1'b1; w_sel_idx = 2'd2; end
        4'b1000: begin w_sel_valid = 1'b1; w_sel_idx = 2'd3; end
        default: begin w_sel_valid = 1'b0; w_sel_idx = 2'd0; end
      endcase
    end else begin
      w_sel_valid = 1'b0;
      w_sel_idx   = 2'd0;
    end
  end

  // Candidate positions for the next tick; arrival is judged on these so the
  // state advances in the same cycle the last servo lands.
  always_comb begin
    w_arrive = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w_next_pos[i] = slew(r_pos[i], r_tgt[i]);
      if (w_next_pos[i] != r_tgt[i]) begin
        w_arrive = 1'b0;
      end else begin
        w_arrive = w_arrive;
      end
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_kf    <= 1'b0;
      r_hold  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_gest  <= 2'd0;
      for (int i = 0; i < 5; i++) begin
        r_pos[i] <= NEUTRAL8;
        r_tgt[i] <= NEUTRAL8;
      end
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_sel_valid) begin
              r_gest  <= w_sel_idx;
              r_kf    <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_MOVE;
              for (int i = 0; i < 5; i++) begin
                r_tgt[i] <= rom_angle(w_sel_idx, 3'(i));
              end
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_MOVE: begin
          if (frame_tick) begin
            for (int i = 0; i < 5; i++) begin
              r_pos[i] <= w_next_pos[i];
            end
            if (w_arrive) begin
              if (!r_kf) begin
                r_hold  <= HOLD_INIT;
                r_state <= S_HOLD;
              end else begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
            end
          end
        end
        S_HOLD: begin
          if (frame_tick) begin
            // The tick that empties the counter also arms the return leg;
            // motion itself begins on the following tick.
            if (r_hold <= HOLD_ONE) begin
              r_hold  <= '0;
              r_kf    <= 1'b1;
              r_state <= S_MOVE;
              for (int i = 0; i < 5; i++) begin
                r_tgt[i] <= NEUTRAL8;
              end
            end else begin
              r_hold <= r_hold - HOLD_ONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pos1           = r_pos[0];
  assign pos2           = r_pos[1];
  assign pos3           = r_pos[2];
  assign pos4           = r_pos[3];
  assign pos5           = r_pos[4];
  assign busy           = r_busy;
  assign done           = r_done;
  assign err            = r_err;
  assign active_gesture = r_gest;

endmodule
